// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: the receiver state encoding,
// default frame and oversampling parameters, and the half-bit index helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_t;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_DEF  = 8;

  // Tick index that lands on the centre of the start bit, counted from the
  // cycle the falling edge is first seen.
  function automatic int half_bit_idx(input int os);
    return os / 2 - 1;
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchroniser for a single asynchronous input. Resets to 1 so
// that an idle-high serial line does not look like a start edge on reset exit.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // Shift the input through the flop chain; oldest stage drives q.
  always_ff @(posedge clk) begin
    if (rst) ff <= '1;
    else     ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver. Samples the synchronised rx line once per bit
// at bit centre using the baud_tick strobe (OVERSAMPLE ticks per bit).
// Optional macro UART_RX_PARITY_EN adds one even-parity bit after the data.
//
//   state  | meaning
//   IDLE   | line idle, waiting for rx_s low
//   START  | counting to start-bit centre, rejects glitches
//   DATA   | sampling DATA_BITS data bits, LSB first
//   PARITY | sampling the even-parity bit (parity build only)
//   STOP   | sampling the stop bit, issues rx_valid / frame_err
//   BREAK  | stop bit was low, waiting for the line to return high
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = DATA_BITS_DEF,
  parameter int OVERSAMPLE  = OVERSAMPLE_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int NW = $clog2(DATA_BITS);
  localparam logic [SW-1:0] S_HALF = SW'(half_bit_idx(OVERSAMPLE));
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DATA_BITS - 1);

  state_t               state;
  logic [SW-1:0]        s;
  logic [NW-1:0]        n;
  logic [DATA_BITS-1:0] shreg;
  logic                 rx_s;

  bit_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  logic par_bad;
  // Even parity: data bits plus parity bit must contain an even number of ones.
  assign par_bad = par_bit ^ (^shreg);
`else
  assign parity_err = 1'b0;
`endif

  assign busy = (state != IDLE);

  // Receiver FSM with registered one-cycle strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      s         <= '0;
      n         <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            s     <= '0;
          end
        end
        START: begin
          if (baud_tick) begin
            if (s == S_HALF) begin
              if (!rx_s) begin
                state <= DATA;
                s     <= '0;
                n     <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        DATA: begin
          if (baud_tick) begin
            if (s == S_LAST) begin
              shreg <= {rx_s, shreg[DATA_BITS-1:1]};
              s     <= '0;
              if (n == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end else begin
                n <= n + 1'b1;
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (baud_tick) begin
            if (s == S_LAST) begin
              par_bit <= rx_s;
              s       <= '0;
              state   <= STOP;
            end else begin
              s <= s + 1'b1;
            end
          end
        end
`endif
        STOP: begin
          if (baud_tick) begin
            if (s == S_LAST) begin
              s <= '0;
`ifdef UART_RX_PARITY_EN
              parity_err <= par_bad;
`endif
              if (rx_s) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
                state    <= IDLE;
              end else begin
                frame_err <= 1'b1;
                state     <= BREAK;
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        BREAK: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: baud_tick every 4 clks, 16x oversampling,
// 64 clks per bit. A monitor counts strobes; the stimulus compares counts,
// data and timing against hand-computed values.
module tb_uart_rx_os;

  localparam int BIT_CLKS = 64;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CLKS = FRAME_BITS * BIT_CLKS;
  // Stop-bit centre measured from the start edge, in clks.
  localparam int STOP_CTR   = FRAME_CLKS - BIT_CLKS / 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       baud_tick = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, parity_err, busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int div = 0;
  int start_cyc = 0;

  int         vcnt = 0, fcnt = 0, pcnt = 0, overlap = 0, wide = 0;
  logic [7:0] last_data = '0, prev_data = '0;
  int         last_cyc = 0, prev_cyc = 0;
  logic       valid_d = 1'b0, ferr_d = 1'b0;

  int v0, f0, p0;

  uart_rx_os #(.DATA_BITS(8), .OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .baud_tick  (baud_tick),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // One-clk tick every fourth clock, changed away from the active edge.
  always @(negedge clk) begin
    baud_tick <= (div == 3);
    div       <= (div + 1) % 4;
  end

  // Strobe monitor.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid) begin
        vcnt      <= vcnt + 1;
        prev_data <= last_data;
        last_data <= rx_data;
        prev_cyc  <= last_cyc;
        last_cyc  <= cyc;
      end
      if (frame_err)  fcnt <= fcnt + 1;
      if (parity_err) pcnt <= pcnt + 1;
      if (rx_valid && frame_err) overlap <= overlap + 1;
      if ((rx_valid && valid_d) || (frame_err && ferr_d)) wide <= wide + 1;
    end
    valid_d <= rx_valid;
    ferr_d  <= frame_err;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stopb, input logic parb);
    start_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(parb);
`else
    if (parb === 1'bx) $display("note: parity bit unknown");
`endif
    send_bit(stopb);
  endtask

  task automatic snap();
    v0 = vcnt;
    f0 = fcnt;
    p0 = pcnt;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_data",  rx_data,    8'h00);
    chk("rst_valid", rx_valid,   1'b0);
    chk("rst_ferr",  frame_err,  1'b0);
    chk("rst_perr",  parity_err, 1'b0);
    chk("rst_busy",  busy,       1'b0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // Clean frame 0x55.
    snap();
    send_frame(8'h55, 1'b1, ^8'h55);
    repeat (2 * BIT_CLKS) @(negedge clk);
    chk("f55_valid", vcnt - v0, 1);
    chk("f55_ferr",  fcnt - f0, 0);
    chk("f55_data",  rx_data, 8'h55);
    chk("f55_busy",  busy, 1'b0);
    chk("f55_lat_lo", (last_cyc - start_cyc) >= STOP_CTR, 1'b1);
    chk("f55_lat_hi", (last_cyc - start_cyc) <= STOP_CTR + 8, 1'b1);

    // Five-tick low glitch is rejected.
    snap();
    rx = 1'b0;
    repeat (10) @(negedge clk);
    chk("gl_busy_in", busy, 1'b1);
    repeat (10) @(negedge clk);
    rx = 1'b1;
    repeat (100) @(negedge clk);
    chk("gl_busy",  busy, 1'b0);
    chk("gl_valid", vcnt - v0, 0);
    chk("gl_ferr",  fcnt - f0, 0);
    chk("gl_data",  rx_data, 8'h55);

    // 0xA3 with low stop bit, line held low 40 more ticks (break).
    snap();
    send_frame(8'hA3, 1'b0, ^8'hA3);
    repeat (160) @(negedge clk);
    chk("brk_busy_low", busy, 1'b1);
    rx = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    chk("brk_ferr",  fcnt - f0, 1);
    chk("brk_valid", vcnt - v0, 0);
    chk("brk_data",  rx_data, 8'h55);
    chk("brk_busy",  busy, 1'b0);
    send_frame(8'h3C, 1'b1, ^8'h3C);
    repeat (2 * BIT_CLKS) @(negedge clk);
    chk("f3c_valid", vcnt - v0, 1);
    chk("f3c_data",  rx_data, 8'h3C);
    chk("f3c_ferr",  fcnt - f0, 1);

    // Back-to-back frames with no idle gap.
    snap();
    send_frame(8'h00, 1'b1, ^8'h00);
    send_frame(8'hFF, 1'b1, ^8'hFF);
    repeat (2 * BIT_CLKS) @(negedge clk);
    chk("b2b_valid", vcnt - v0, 2);
    chk("b2b_d0",    prev_data, 8'h00);
    chk("b2b_d1",    last_data, 8'hFF);
    chk("b2b_gap",   last_cyc - prev_cyc, FRAME_CLKS);
    chk("b2b_ferr",  fcnt - f0, 0);

    // Reset during data bit 4 of 0xC6.
    snap();
    start_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'(8'hC6 >> i));
    rx = 1'b0;
    repeat (BIT_CLKS / 2) @(negedge clk);
    chk("mr_busy_pre", busy, 1'b1);
    rst = 1'b1;
    rx  = 1'b1;
    repeat (2) @(negedge clk);
    chk("mr_data",  rx_data,    8'h00);
    chk("mr_valid", rx_valid,   1'b0);
    chk("mr_ferr",  frame_err,  1'b0);
    chk("mr_perr",  parity_err, 1'b0);
    chk("mr_busy",  busy,       1'b0);
    rst = 1'b0;
    repeat (3 * BIT_CLKS) @(negedge clk);
    chk("mr_nostb", (vcnt - v0) + (fcnt - f0), 0);
    chk("mr_data2", rx_data, 8'h00);
    send_frame(8'h81, 1'b1, ^8'h81);
    repeat (2 * BIT_CLKS) @(negedge clk);
    chk("f81_valid", vcnt - v0, 1);
    chk("f81_data",  rx_data, 8'h81);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones, so the even-parity bit must be 1.
    snap();
    send_frame(8'h07, 1'b1, 1'b0);
    repeat (2 * BIT_CLKS) @(negedge clk);
    chk("pbad_perr",  pcnt - p0, 1);
    chk("pbad_valid", vcnt - v0, 1);
    chk("pbad_data",  rx_data, 8'h07);
    snap();
    send_frame(8'h07, 1'b1, 1'b1);
    repeat (2 * BIT_CLKS) @(negedge clk);
    chk("pok_perr",  pcnt - p0, 0);
    chk("pok_valid", vcnt - v0, 1);
`else
    chk("par_tied", pcnt, 0);
`endif

    chk("overlap",  overlap, 0);
    chk("pulse_w",  wide, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
